// File: rtl/pll_sweep_ctrl.sv
// PLL frequency-sweep scheduler for BER measurements.
// Steps the PLL DRP configuration address from ADDR_FIRST to ADDR_LAST. For each step it
// waits for relock, lets the clock settle, counts BER error strobes over a fixed dwell
// window, and reports one result per address.
// Optional build macro PLL_SWEEP_LOOP_EN: the sweep restarts at ADDR_FIRST after
// ADDR_LAST and runs until STOP or RST.
module pll_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 1024,
  parameter int unsigned DWELL_CYC  = 1000000,
  parameter int unsigned LOCK_TMO   = 65535,
  parameter int unsigned UNLOCK_TMO = 64,
  parameter int unsigned ECW        = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           STOP,
  input  logic [3:0]     ADDR_FIRST,
  input  logic [3:0]     ADDR_LAST,
  input  logic           LOCK,
  input  logic           ERR_IN,
  output logic [3:0]     PLL_ADDR,
  output logic           PLL_CHG,
  output logic           BUSY,
  output logic           RES_VALID,
  output logic [3:0]     RES_ADDR,
  output logic [ECW-1:0] RES_ERR,
  output logic           RES_TMO,
  output logic           DONE
);

  localparam int unsigned MaxA   = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int unsigned MaxB   = (LOCK_TMO > UNLOCK_TMO) ? LOCK_TMO : UNLOCK_TMO;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);

  localparam logic [TW-1:0] SettleLast = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] DwellLast  = TW'(DWELL_CYC - 1);
  localparam logic [TW-1:0] LockLast   = TW'(LOCK_TMO - 1);
  localparam logic [TW-1:0] UnlkLast   = TW'(UNLOCK_TMO - 1);

  typedef enum logic [2:0] {
    StIdle, StChg, StWaitUnlk, StWaitLk, StSettle, StDwell, StReport, StNext
  } state_e;

  state_e         state_q;
  logic [TW-1:0]  timer_q;
  logic [3:0]     cur_q;
  logic [3:0]     last_q;
  logic [ECW-1:0] err_q;
  logic           tmo_q;
  logic           lock_meta_q;
  logic           lock_s_q;
`ifdef PLL_SWEEP_LOOP_EN
  logic [3:0]     first_q;
`endif

  logic [ECW-1:0] err_inc;
  logic [3:0]     cur_inc;

  // LOCK is asynchronous to CLK: two-flop synchronizer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Saturating error accumulate and next sweep address
  always_comb begin
    err_inc = err_q;
    if (ERR_IN && (err_q != '1)) begin
      err_inc = err_q + ECW'(1);
    end
    cur_inc = cur_q + 4'd1;
  end

  // Sweep sequencer with registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      cur_q     <= '0;
      last_q    <= '0;
      err_q     <= '0;
      tmo_q     <= 1'b0;
      PLL_ADDR  <= '0;
      PLL_CHG   <= 1'b0;
      BUSY      <= 1'b0;
      RES_VALID <= 1'b0;
      RES_ADDR  <= '0;
      RES_ERR   <= '0;
      RES_TMO   <= 1'b0;
      DONE      <= 1'b0;
`ifdef PLL_SWEEP_LOOP_EN
      first_q   <= '0;
`endif
    end else begin
      PLL_CHG   <= 1'b0;
      RES_VALID <= 1'b0;
      DONE      <= 1'b0;
      if (STOP && (state_q != StIdle)) begin
        // Abort: pending pulses are dropped, PLL_ADDR and RES_* keep their values
        state_q <= StIdle;
        BUSY    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (START && !STOP) begin
              cur_q    <= ADDR_FIRST;
              last_q   <= ADDR_LAST;
`ifdef PLL_SWEEP_LOOP_EN
              first_q  <= ADDR_FIRST;
`endif
              BUSY     <= 1'b1;
              PLL_ADDR <= ADDR_FIRST;
              PLL_CHG  <= 1'b1;
              err_q    <= '0;
              tmo_q    <= 1'b0;
              state_q  <= StChg;
            end
          end
          StChg: begin
            timer_q <= '0;
            state_q <= StWaitUnlk;
          end
          StWaitUnlk: begin
            // The PLL may relock before the synchronizer sees the drop, so give up waiting
            if (!lock_s_q || (timer_q == UnlkLast)) begin
              timer_q <= '0;
              state_q <= StWaitLk;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          StWaitLk: begin
            if (lock_s_q) begin
              timer_q <= '0;
              state_q <= StSettle;
            end else if (timer_q == LockLast) begin
              err_q     <= '1;
              tmo_q     <= 1'b1;
              RES_VALID <= 1'b1;
              RES_ADDR  <= cur_q;
              RES_ERR   <= '1;
              RES_TMO   <= 1'b1;
              state_q   <= StReport;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          StSettle: begin
            if (!lock_s_q) begin
              timer_q <= '0;
              state_q <= StWaitLk;
            end else if (timer_q == SettleLast) begin
              timer_q <= '0;
              state_q <= StDwell;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          StDwell: begin
            err_q <= err_inc;
            tmo_q <= tmo_q | ~lock_s_q;
            if (timer_q == DwellLast) begin
              RES_VALID <= 1'b1;
              RES_ADDR  <= cur_q;
              RES_ERR   <= err_inc;
              RES_TMO   <= tmo_q | ~lock_s_q;
              state_q   <= StReport;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          StReport: begin
            state_q <= StNext;
          end
          StNext: begin
            if (cur_q == last_q) begin
              DONE <= 1'b1;
`ifdef PLL_SWEEP_LOOP_EN
              cur_q    <= first_q;
              PLL_ADDR <= first_q;
              PLL_CHG  <= 1'b1;
              err_q    <= '0;
              tmo_q    <= 1'b0;
              state_q  <= StChg;
`else
              BUSY    <= 1'b0;
              state_q <= StIdle;
`endif
            end else begin
              cur_q    <= cur_inc;
              PLL_ADDR <= cur_inc;
              PLL_CHG  <= 1'b1;
              err_q    <= '0;
              tmo_q    <= 1'b0;
              state_q  <= StChg;
            end
          end
          default: begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_sweep_ctrl.sv
// Scoreboard bench for pll_sweep_ctrl: a PLL/BER model drives LOCK and ERR_IN, the expected
// per-address results are queued at START and popped by a monitor on each DUT output pulse.
// A second instance with ECW=4 shares the stimulus to exercise counter saturation.
module tb_pll_sweep_ctrl;

  localparam int unsigned SettleCyc = 8;
  localparam int unsigned DwellCyc  = 100;
  localparam int unsigned LockTmo   = 50;
  localparam int unsigned UnlockTmo = 16;

  logic        CLK = 1'b0;
  logic        RST, START, STOP, LOCK, ERR_IN;
  logic [3:0]  ADDR_FIRST, ADDR_LAST;
  logic [3:0]  PLL_ADDR, RES_ADDR;
  logic        PLL_CHG, BUSY, RES_VALID, RES_TMO, DONE;
  logic [15:0] RES_ERR;
  logic [3:0]  PLL_ADDR_4, RES_ADDR_4;
  logic        PLL_CHG_4, BUSY_4, RES_VALID_4, RES_TMO_4, DONE_4;
  logic [3:0]  RES_ERR_4;

  pll_sweep_ctrl #(
    .SETTLE_CYC(SettleCyc), .DWELL_CYC(DwellCyc), .LOCK_TMO(LockTmo),
    .UNLOCK_TMO(UnlockTmo), .ECW(16)
  ) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .ADDR_FIRST(ADDR_FIRST),
    .ADDR_LAST(ADDR_LAST), .LOCK(LOCK), .ERR_IN(ERR_IN), .PLL_ADDR(PLL_ADDR),
    .PLL_CHG(PLL_CHG), .BUSY(BUSY), .RES_VALID(RES_VALID), .RES_ADDR(RES_ADDR),
    .RES_ERR(RES_ERR), .RES_TMO(RES_TMO), .DONE(DONE)
  );

  pll_sweep_ctrl #(
    .SETTLE_CYC(SettleCyc), .DWELL_CYC(DwellCyc), .LOCK_TMO(LockTmo),
    .UNLOCK_TMO(UnlockTmo), .ECW(4)
  ) u_dut_w4 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .ADDR_FIRST(ADDR_FIRST),
    .ADDR_LAST(ADDR_LAST), .LOCK(LOCK), .ERR_IN(ERR_IN), .PLL_ADDR(PLL_ADDR_4),
    .PLL_CHG(PLL_CHG_4), .BUSY(BUSY_4), .RES_VALID(RES_VALID_4), .RES_ADDR(RES_ADDR_4),
    .RES_ERR(RES_ERR_4), .RES_TMO(RES_TMO_4), .DONE(DONE_4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int addr;
    int cnt;
    bit tmo;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t q0[$];
  res_t q1[$];
  int   chg_q[$];
  int   done_seen = 0;

  // Model configuration, written only by the main stimulus process
  int n_plan[16];
  bit norelock[16];
  bit hold_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_err(input res_t r, input int w);
    int sat;
    sat = (1 << w) - 1;
    if (r.tmo) return sat;
    return (r.cnt > sat) ? sat : r.cnt;
  endfunction

  // PLL model: lock drops 3 cycles after a change request and returns 20 cycles later
  // (never, for addresses marked norelock). Errors are injected well inside the dwell.
  int m_cnt;
  bit m_active;
  int m_addr;
  initial begin
    LOCK = 1'b1;
    ERR_IN = 1'b0;
    m_active = 1'b0;
    m_cnt = 0;
    m_addr = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) m_active = 1'b0;
      else if (PLL_CHG) begin
        m_active = 1'b1;
        m_cnt = 0;
        m_addr = int'(PLL_ADDR);
      end else if (m_active) m_cnt++;
      if (!m_active) LOCK = 1'b1;
      else if (m_cnt == 3) LOCK = 1'b0;
      else if (m_cnt == 23 && !norelock[m_addr]) LOCK = 1'b1;
      ERR_IN = hold_err || (m_active && m_cnt >= 43 && m_cnt < 43 + n_plan[m_addr]);
    end
  end

  // Monitor: pop and compare on every output pulse
  always @(negedge CLK) begin
    if (!RST) begin
      if (PLL_CHG) begin
        chk("chg_expected", int'(chg_q.size() > 0), 1);
        if (chg_q.size() > 0) chk("chg_addr", int'(PLL_ADDR), chg_q.pop_front());
      end
      if (RES_VALID) begin
        chk("res_expected", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          res_t r;
          r = q0.pop_front();
          chk("res_addr", int'(RES_ADDR), r.addr);
          chk("res_err", int'(RES_ERR), exp_err(r, 16));
          chk("res_tmo", int'(RES_TMO), int'(r.tmo));
        end
      end
      if (RES_VALID_4) begin
        chk("res4_expected", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          res_t r;
          r = q1.pop_front();
          chk("res4_addr", int'(RES_ADDR_4), r.addr);
          chk("res4_err", int'(RES_ERR_4), exp_err(r, 4));
          chk("res4_tmo", int'(RES_TMO_4), int'(r.tmo));
        end
      end
      if (DONE) done_seen++;
    end
  end

  task automatic push_steps(input int first, input int nres, input int nchg);
    int a;
    res_t r;
    a = first;
    for (int i = 0; i < nchg; i++) begin
      chg_q.push_back(a);
      if (i < nres) begin
        r.addr = a;
        r.tmo  = norelock[a];
        r.cnt  = hold_err ? int'(DwellCyc) : n_plan[a];
        q0.push_back(r);
        q1.push_back(r);
      end
      a = (a + 1) % 16;
    end
  endtask

  task automatic pulse_start(input int f, input int l);
    @(negedge CLK);
    ADDR_FIRST = 4'(f);
    ADDR_LAST  = 4'(l);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ADDR_FIRST = 4'($urandom_range(0, 15));
    ADDR_LAST  = 4'($urandom_range(0, 15));
    chk("start_latency_chg", int'(PLL_CHG), 1);
    chk("start_busy", int'(BUSY), 1);
  endtask

  task automatic pulse_stop();
    @(negedge CLK);
    STOP = 1'b1;
    @(negedge CLK);
    STOP = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_drop_in_time", int'(BUSY), 0);
    @(negedge CLK);
  endtask

  task automatic run_sweep(input int f, input int l, input bit poke);
    int nsteps, d0;
    nsteps = ((l - f + 16) % 16) + 1;
    d0 = done_seen;
    push_steps(f, nsteps, nsteps);
    pulse_start(f, l);
    if (poke) begin
      // START while busy must be ignored
      wait_cycles(30);
      pulse_start_ignored();
    end
    wait_idle(nsteps * 400);
    chk("done_count", done_seen - d0, 1);
    chk("res_q_drained", q0.size() + q1.size(), 0);
    chk("chg_q_drained", chg_q.size(), 0);
  endtask

  task automatic pulse_start_ignored();
    @(negedge CLK);
    ADDR_FIRST = 4'd10;
    ADDR_LAST  = 4'd12;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pll_addr"}, int'(PLL_ADDR), 0);
    chk({tag, "_pll_chg"}, int'(PLL_CHG), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_res_valid"}, int'(RES_VALID), 0);
    chk({tag, "_res_addr"}, int'(RES_ADDR), 0);
    chk({tag, "_res_err"}, int'(RES_ERR), 0);
    chk({tag, "_res_tmo"}, int'(RES_TMO), 0);
    chk({tag, "_done"}, int'(DONE), 0);
  endtask

  initial begin
    int n, d0, f, l;
    RST = 1'b1;
    START = 1'b0;
    STOP = 1'b0;
    ADDR_FIRST = '0;
    ADDR_LAST = '0;
    hold_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_plan[i] = 0;
      norelock[i] = 1'b0;
    end
    wait_cycles(3);
    chk_outputs_zero("reset");
    RST = 1'b0;
    wait_cycles(2);
    chk("idle_busy", int'(BUSY), 0);

`ifdef PLL_SWEEP_LOOP_EN
    // Looping sweep 0,1,0,1,... with DONE after each 1; STOP ends it
    d0 = done_seen;
    push_steps(0, 4, 5);
    pulse_start(0, 1);
    n = 0;
    while (done_seen - d0 < 2 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("loop_done_count", done_seen - d0, 2);
    chk("loop_busy", int'(BUSY), 1);
    pulse_stop();
    chk("loop_stop_busy", int'(BUSY), 0);
    wait_cycles(50);
    chk("loop_res_q_drained", q0.size() + q1.size(), 0);
    chk("loop_chg_q_drained", chg_q.size(), 0);
`else
    // Basic sweep with a START poked while busy
    run_sweep(2, 4, 1'b1);
    chk("basic_busy_after", int'(BUSY), 0);

    // Error count
    n_plan[5] = 37;
    run_sweep(5, 5, 1'b0);
    n_plan[5] = 0;

    // ERR_IN held high over the whole step: full dwell count, and saturation at ECW=4
    hold_err = 1'b1;
    run_sweep(3, 3, 1'b0);
    hold_err = 1'b0;

    // Reset while waiting for lock: outputs clear immediately
    norelock[7] = 1'b1;
    chg_q.push_back(7);
    pulse_start(7, 7);
    wait_cycles(25);
    chk("pre_reset_busy", int'(BUSY), 1);
    #2;
    RST = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    wait_cycles(2);
    RST = 1'b0;
    norelock[7] = 1'b0;
    wait_cycles(3);

    // Lock timeout on address 7, sweep continues to 8
    norelock[7] = 1'b1;
    run_sweep(6, 8, 1'b0);
    norelock[7] = 1'b0;

    // Wrap-around and single-step sweeps
    run_sweep(14, 1, 1'b0);
    run_sweep(9, 9, 1'b0);

    // Randomised short sweeps with random error counts
    repeat (4) begin
      f = int'($urandom_range(0, 15));
      l = (f + int'($urandom_range(0, 2))) % 16;
      for (int i = 0; i < 16; i++) n_plan[i] = int'($urandom_range(0, 60));
      run_sweep(f, l, 1'b0);
    end
    for (int i = 0; i < 16; i++) n_plan[i] = 0;

    // STOP during the dwell of step 2 of 4
    d0 = done_seen;
    push_steps(1, 1, 2);
    pulse_start(1, 4);
    n = 0;
    while (chg_q.size() > 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reached_step2", chg_q.size(), 0);
    wait_cycles(60);
    pulse_stop();
    chk("abort_busy", int'(BUSY), 0);
    wait_cycles(300);
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_res_q_drained", q0.size() + q1.size(), 0);
    chk("abort_pll_addr_kept", int'(PLL_ADDR), 2);
    chk("abort_still_idle", int'(BUSY), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
